ej32_ifetch: RTL and testbench



---
 rtl/ej32_ifetch_if.sv | 34 +++
 rtl/ej32_ifetch.sv | 82 ++++++++
 tb/tb_ej32_ifetch.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ej32_ifetch_if.sv
// Fetch-unit bus bundle: redirect input, memory read port and bytecode stream.
// Latency: none, wires only.
// Backpressure: ib_rdy stalls the byte stream; mem_gnt stalls memory requests.
//
// Ports (master = fetch unit side):
//   br_psel/br_p          redirect request and target from the branching unit
//   mem_req/mem_a         byte read request and address to the memory arbiter
//   mem_gnt/ram_d         grant from the arbiter, read data one cycle later
//   ib_vld/ib_d/ib_rdy    bytecode stream handshake towards decode
//   p                     address of the head byte (instruction pointer)
interface ej32_ifetch_if #(
   parameter int ASZ = 17
);
   logic           br_psel;
   logic [ASZ-1:0] br_p;
   logic           mem_req;
   logic [ASZ-1:0] mem_a;
   logic           mem_gnt;
   logic [7:0]     ram_d;
   logic           ib_vld;
   logic [7:0]     ib_d;
   logic           ib_rdy;
   logic [ASZ-1:0] p;

   modport master (
      input  br_psel, br_p, mem_gnt, ram_d, ib_rdy,
      output mem_req, mem_a, ib_vld, ib_d, p
   );

   modport slave (
      output br_psel, br_p, mem_gnt, ram_d, ib_rdy,
      input  mem_req, mem_a, ib_vld, ib_d, p
   );
endinterface

// File: rtl/ej32_ifetch.sv
// eJ32 instruction fetch: byte reads into a DEPTH-entry prefetch FIFO, redirectable.
// Latency: grant to ib_vld 2 cycles; redirect to first byte 3 cycles; no bypass.
// Backpressure: requests stop once buffered + in-flight bytes reach DEPTH; ib_rdy pops.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     ej32_ifetch_if master modport (redirect, memory port, byte stream, p)
module ej32_ifetch #(
   parameter int ASZ   = 17,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   ej32_ifetch_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]     r_mem [DEPTH];
   logic [AW-1:0]  r_wr;
   logic [AW-1:0]  r_rd;
   logic [CW-1:0]  r_cnt;
   logic           r_rvld;
   logic [ASZ-1:0] r_fa;
   logic [ASZ-1:0] r_p;

   logic [CW:0]    w_used;
   logic           w_req;
   logic           w_acc;
   logic           w_push;
   logic           w_pop;
   logic           w_vld;

   // Credit counts the in-flight byte as occupied, and a pop in this cycle
   // does not free a slot until next cycle, so the FIFO can never overflow.
   assign w_used = {1'b0, r_cnt} + {{CW{1'b0}}, r_rvld};
   assign w_req  = rst_n & (w_used < (CW+1)'(DEPTH));
   assign w_acc  = w_req & bus.mem_gnt;
   assign w_vld  = (r_cnt != '0);
   // A redirect discards both the returning byte and the consumer's take.
   assign w_push = r_rvld & ~bus.br_psel;
   assign w_pop  = w_vld & bus.ib_rdy & ~bus.br_psel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
         r_wr   <= '0;
         r_rd   <= '0;
         r_cnt  <= '0;
         r_rvld <= 1'b0;
         r_fa   <= '0;
         r_p    <= '0;
      end else if (bus.br_psel) begin
         // Any grant this cycle was for the old stream; never expect its data.
         r_wr   <= '0;
         r_rd   <= '0;
         r_cnt  <= '0;
         r_rvld <= 1'b0;
         r_fa   <= bus.br_p;
         r_p    <= bus.br_p;
      end else begin
         r_rvld <= w_acc;
         if (w_acc) r_fa <= r_fa + 1'b1;
         if (w_push) begin
            r_mem[r_wr] <= bus.ram_d;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
            r_p  <= r_p + 1'b1;
         end
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   assign bus.mem_req = w_req;
   assign bus.mem_a   = r_fa;
   assign bus.ib_vld  = w_vld;
   assign bus.ib_d    = r_mem[r_rd];
   assign bus.p       = r_p;
endmodule

// File: tb/tb_ej32_ifetch.sv
// Directed bench for ej32_ifetch: memory returns the low address byte one cycle after a grant.
module tb_ej32_ifetch;
   localparam int ASZ = 17;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   ej32_ifetch_if #(.ASZ(ASZ)) bus ();

   ej32_ifetch #(.ASZ(ASZ), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory: data for an accepted request appears on the next cycle; 0xEE otherwise.
   always @(posedge clk)
      bus.ram_d <= (bus.mem_req && bus.mem_gnt) ? bus.mem_a[7:0] : 8'hEE;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [ASZ-1:0] a);
      bus.br_p    = a;
      bus.br_psel = 1'b1;
      tick();
      bus.br_psel = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n       = 1'b0;
      bus.br_psel = 1'b0;
      bus.br_p    = '0;
      bus.mem_gnt = 1'b1;
      bus.ib_rdy  = 1'b1;
      #2;
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_a",   bus.mem_a,   0);
      chk("rst_ib_vld",  bus.ib_vld,  0);
      chk("rst_ib_d",    bus.ib_d,    0);
      chk("rst_p",       bus.p,       0);

      // Cold fetch: first grant in cycle 0, first byte visible in cycle 2.
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      chk("cold_req", bus.mem_req, 1);
      chk("cold_a",   bus.mem_a,   0);
      tick();
      chk("cold_vld_c1", bus.ib_vld, 0);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("cold_vld", bus.ib_vld, 1);
         chk("cold_d",   bus.ib_d,   k);
         chk("cold_p",   bus.p,      k);
         tick();
      end

      // Backpressure: four bytes buffered, requests stop, then drain in order.
      bus.ib_rdy = 1'b0;
      redirect(17'h00100);
      chk("bp_a",   bus.mem_a,   17'h00100);
      chk("bp_req", bus.mem_req, 1);
      chk("bp_vld", bus.ib_vld,  0);
      repeat (4) tick();
      chk("bp_req_drop", bus.mem_req, 0);
      repeat (5) tick();
      chk("bp_req_held", bus.mem_req, 0);
      bus.ib_rdy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk("bp_out_vld", bus.ib_vld, 1);
         chk("bp_out_d",   bus.ib_d,   k);
         chk("bp_out_p",   bus.p,      17'h00100 + k);
         tick();
      end

      // Redirect while a response is in flight: stale byte must vanish.
      redirect(17'h01234);
      chk("rd_vld_r1", bus.ib_vld, 0);
      chk("rd_a",      bus.mem_a,  17'h01234);
      tick();
      chk("rd_vld_r2", bus.ib_vld, 0);
      tick();
      chk("rd_vld_r3", bus.ib_vld, 1);
      chk("rd_p",      bus.p,      17'h01234);
      chk("rd_d",      bus.ib_d,   8'h34);
      tick();
      chk("rd_p_next", bus.p,      17'h01235);
      chk("rd_d_next", bus.ib_d,   8'h35);

      // Grant stall for five cycles at 0x0010.
      bus.mem_gnt = 1'b0;
      redirect(17'h00010);
      for (int k = 0; k < 5; k++) begin
         chk("stall_req", bus.mem_req, 1);
         chk("stall_a",   bus.mem_a,   17'h00010);
         chk("stall_vld", bus.ib_vld,  0);
         tick();
      end
      bus.mem_gnt = 1'b1;
      chk("stall_a_gnt", bus.mem_a, 17'h00010);
      tick();
      chk("stall_vld_g1", bus.ib_vld, 0);
      tick();
      chk("stall_vld_g2", bus.ib_vld, 1);
      chk("stall_d",      bus.ib_d,   8'h10);
      chk("stall_p",      bus.p,      17'h00010);

      // Address wrap, then redirect coinciding with push and pop.
      redirect(17'h1FFFF);
      repeat (2) tick();
      chk("wrap_p_hi", bus.p,    17'h1FFFF);
      chk("wrap_d_hi", bus.ib_d, 8'hFF);
      tick();
      chk("wrap_p_lo", bus.p,    17'h00000);
      chk("wrap_d_lo", bus.ib_d, 8'h00);
      redirect(17'h00ABC);
      chk("sim_vld", bus.ib_vld, 0);
      chk("sim_p",   bus.p,      17'h00ABC);
      repeat (2) tick();
      chk("sim_vld_r3", bus.ib_vld, 1);
      chk("sim_d",      bus.ib_d,   8'hBC);
      chk("sim_p_r3",   bus.p,      17'h00ABC);

      // Asynchronous reset mid-cycle with three bytes buffered.
      bus.ib_rdy = 1'b0;
      redirect(17'h00200);
      repeat (4) tick();
      chk("ar_vld_pre", bus.ib_vld, 1);
      chk("ar_d_pre",   bus.ib_d,   8'h00);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_vld", bus.ib_vld,  0);
      chk("ar_req", bus.mem_req, 0);
      chk("ar_p",   bus.p,       0);
      chk("ar_a",   bus.mem_a,   0);
      tick();
      #3 rst_n = 1'b1;
      bus.ib_rdy = 1'b1;
      #1;
      chk("ar_rel_req", bus.mem_req, 1);
      chk("ar_rel_a",   bus.mem_a,   0);
      tick();
      chk("ar_vld_c1", bus.ib_vld, 0);
      tick();
      chk("ar_vld_c2", bus.ib_vld, 1);
      chk("ar_d0",     bus.ib_d,   8'h00);
      chk("ar_p0",     bus.p,      0);
      tick();
      chk("ar_d1", bus.ib_d, 8'h01);
      chk("ar_p1", bus.p,    1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
